alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 44 ++++
 rtl/alu_issue_fwd_mux.sv | 25 ++
 rtl/alu_issue.sv | 128 ++++++++++++
 tb/tb_alu_issue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage and the ALU: widths, opcodes,
// the held-instruction record and small decode/forwarding helpers.
package alu_issue_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int OPW  = 4;

    localparam logic [OPW-1:0] ALU_AND  = 4'b0000;
    localparam logic [OPW-1:0] ALU_OR   = 4'b0001;
    localparam logic [OPW-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OPW-1:0] ALU_XOR  = 4'b0011;
    localparam logic [OPW-1:0] ALU_SLL  = 4'b0100;
    localparam logic [OPW-1:0] ALU_SRL  = 4'b0101;
    localparam logic [OPW-1:0] ALU_SUB  = 4'b0110;
    localparam logic [OPW-1:0] ALU_SLTU = 4'b0111;
    localparam logic [OPW-1:0] ALU_SLT  = 4'b1000;
    localparam logic [OPW-1:0] ALU_SRA  = 4'b1001;

    typedef struct packed {
        logic [OPW-1:0]  aluop;
        logic            illegal;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            reg_write;
    } issue_entry_t;

    function automatic logic is_legal_op(input logic [OPW-1:0] op);
        return op <= ALU_SRA;
    endfunction

    // x0 is hardwired to zero, so a write to it must never be picked up
    function automatic logic fwd_hit(input logic we,
                                     input logic [REGW-1:0] src_rd,
                                     input logic [REGW-1:0] rs);
        return we && (src_rd != '0) && (src_rd == rs);
    endfunction

endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Operand forwarding select for one source register; EX/MEM wins over MEM/WB.
module fwd_mux
    import alu_issue_pkg::*;
(
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rdata,
    input  logic            exmem_we,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_we,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] operand
);

    always_comb begin
        operand = rdata;
        if (fwd_hit(exmem_we, exmem_rd, rs)) begin
            operand = exmem_result;
        end else if (fwd_hit(memwb_we, memwb_rd, rs)) begin
            operand = memwb_result;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: a one-entry valid/ready holding register between decode and
// EX, with illegal-opcode squashing, writeback refresh and operand forwarding.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_aluop,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [REGW-1:0] in_rd,
    input  logic [XLEN-1:0] in_rdata1,
    input  logic [XLEN-1:0] in_rdata2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic            in_reg_write,
    input  logic            flush,
    input  logic            exmem_we,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_we,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [OPW-1:0]  out_aluop,
    output logic [XLEN-1:0] out_ina,
    output logic [XLEN-1:0] out_inb,
    output logic [REGW-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_illegal
);

    issue_entry_t held;
    issue_entry_t incoming;
    logic         valid_q;
    logic         capture;
    logic         hold;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign hold     = valid_q && !out_ready;

    // Illegal opcodes become a harmless ADD that never writes the register file
    always_comb begin
        incoming.aluop     = in_aluop;
        incoming.illegal   = 1'b0;
        incoming.rs1       = in_rs1;
        incoming.rs2       = in_rs2;
        incoming.rd        = in_rd;
        incoming.rdata1    = in_rdata1;
        incoming.rdata2    = in_rdata2;
        incoming.imm       = in_imm;
        incoming.use_imm   = in_use_imm;
        incoming.reg_write = in_reg_write;
        if (!is_legal_op(in_aluop)) begin
            incoming.aluop     = ALU_ADD;
            incoming.illegal   = 1'b1;
            incoming.reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // While stalled, the register file may be written behind our back; keep the
    // stored sources current so they stay right once MEM/WB moves on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held <= '0;
        end else if (capture) begin
            held <= incoming;
        end else if (hold) begin
            if (fwd_hit(memwb_we, memwb_rd, held.rs1)) begin
                held.rdata1 <= memwb_result;
            end
            if (fwd_hit(memwb_we, memwb_rd, held.rs2)) begin
                held.rdata2 <= memwb_result;
            end
        end
    end

    fwd_mux u_fwd_a (
        .rs           (held.rs1),
        .rdata        (held.rdata1),
        .exmem_we     (exmem_we),
        .exmem_rd     (exmem_rd),
        .exmem_result (exmem_result),
        .memwb_we     (memwb_we),
        .memwb_rd     (memwb_rd),
        .memwb_result (memwb_result),
        .operand      (fwd_a)
    );

    fwd_mux u_fwd_b (
        .rs           (held.rs2),
        .rdata        (held.rdata2),
        .exmem_we     (exmem_we),
        .exmem_rd     (exmem_rd),
        .exmem_result (exmem_result),
        .memwb_we     (memwb_we),
        .memwb_rd     (memwb_rd),
        .memwb_result (memwb_result),
        .operand      (fwd_b)
    );

    assign out_valid     = valid_q;
    assign out_aluop     = held.aluop;
    assign out_ina       = fwd_a;
    assign out_inb       = held.use_imm ? held.imm : fwd_b;
    assign out_rd        = held.rd;
    assign out_reg_write = held.reg_write && valid_q;
    assign out_illegal   = held.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: capture, forwarding, writeback refresh, flush,
// illegal opcode squashing and reset while holding.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_aluop;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rdata1, in_rdata2, in_imm;
    logic        in_use_imm, in_reg_write;
    logic        flush;
    logic        exmem_we;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_we;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_aluop;
    logic [31:0] out_ina, out_inb;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    alu_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_aluop      (in_aluop),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .in_rdata1     (in_rdata1),
        .in_rdata2     (in_rdata2),
        .in_imm        (in_imm),
        .in_use_imm    (in_use_imm),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
        .exmem_we      (exmem_we),
        .exmem_rd      (exmem_rd),
        .exmem_result  (exmem_result),
        .memwb_we      (memwb_we),
        .memwb_rd      (memwb_rd),
        .memwb_result  (memwb_result),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_aluop     (out_aluop),
        .out_ina       (out_ina),
        .out_inb       (out_inb),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_illegal   (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic use_imm,
                                 input logic rw);
        in_valid     = 1'b1;
        in_aluop     = op;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rd        = rd;
        in_rdata1    = d1;
        in_rdata2    = d2;
        in_imm       = imm;
        in_use_imm   = use_imm;
        in_reg_write = rw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_aluop = '0; in_rs1 = '0; in_rs2 = '0;
        in_rd = '0; in_rdata1 = '0; in_rdata2 = '0; in_imm = '0; in_use_imm = 1'b0;
        in_reg_write = 1'b0; flush = 1'b0; exmem_we = 1'b0; exmem_rd = '0;
        exmem_result = '0; memwb_we = 1'b0; memwb_rd = '0; memwb_result = '0;
        out_ready = 1'b1;

        tick(); tick();
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset out_illegal", {31'd0, out_illegal}, 32'd0);
        checkOutput("reset out_ina", out_ina, 32'd0);
        rst_n = 1'b1;
        tick();

        // Plain ADD capture with latency one
        applyStimulus(4'b0010, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("add out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("add out_ina", out_ina, 32'd5);
        checkOutput("add out_inb", out_inb, 32'd7);
        checkOutput("add out_aluop", {28'd0, out_aluop}, 32'h2);
        checkOutput("add out_rd", {27'd0, out_rd}, 32'd5);
        checkOutput("add out_reg_write", {31'd0, out_reg_write}, 32'd1);
        tick();
        checkOutput("retire out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("retire out_reg_write", {31'd0, out_reg_write}, 32'd0);

        // Forwarding priority on a held rs1=3 instruction
        out_ready = 1'b0;
        applyStimulus(4'b0000, 5'd3, 5'd6, 5'd9, 32'h11, 32'h22, 32'd0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("hold in_ready", {31'd0, in_ready}, 32'd0);
        exmem_we = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
        memwb_we = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBB;
        #1;
        checkOutput("fwd exmem priority", out_ina, 32'hAA);
        checkOutput("fwd rs2 no match", out_inb, 32'h22);
        exmem_we = 1'b0;
        #1;
        checkOutput("fwd memwb", out_ina, 32'hBB);
        exmem_we = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        checkOutput("fwd rd0 ignored", out_ina, 32'h11);
        exmem_we = 1'b0; memwb_we = 1'b0;

        // Back-to-back retire and capture, then writeback refresh during a stall
        out_ready = 1'b1;
        applyStimulus(4'b0110, 5'd8, 5'd4, 5'd10, 32'h33, 32'h5, 32'd0, 1'b0, 1'b1);
        #1;
        checkOutput("b2b in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("b2b out_aluop", {28'd0, out_aluop}, 32'h6);
        memwb_we = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h1234;
        tick();
        memwb_we = 1'b0; memwb_result = 32'h0;
        tick();
        tick();
        checkOutput("refresh out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("refresh out_inb", out_inb, 32'h1234);
        checkOutput("refresh out_ina kept", out_ina, 32'h33);
        out_ready = 1'b1;
        tick();
        checkOutput("refresh retired", {31'd0, out_valid}, 32'd0);

        // Flush while empty discards the incoming beat
        applyStimulus(4'b0001, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        checkOutput("flush in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checkOutput("flush empty out_valid", {31'd0, out_valid}, 32'd0);

        // Flush during hold
        out_ready = 1'b0;
        applyStimulus(4'b0011, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("pre-flush out_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush hold out_valid", {31'd0, out_valid}, 32'd0);

        // Illegal opcode with immediate operand B, held for the reset test
        applyStimulus(4'b1100, 5'd1, 5'd7, 5'd12, 32'd1, 32'd2, 32'h99, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        exmem_we = 1'b1; exmem_rd = 5'd7; exmem_result = 32'hDEAD;
        #1;
        checkOutput("illegal out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("illegal out_aluop", {28'd0, out_aluop}, 32'h2);
        checkOutput("illegal out_illegal", {31'd0, out_illegal}, 32'd1);
        checkOutput("illegal out_reg_write", {31'd0, out_reg_write}, 32'd0);
        checkOutput("imm no forward", out_inb, 32'h99);
        exmem_we = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;

        // Reset mid-hold drops the instruction
        rst_n = 1'b0;
        tick();
        checkOutput("rst out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst out_illegal", {31'd0, out_illegal}, 32'd0);
        checkOutput("rst out_aluop", {28'd0, out_aluop}, 32'd0);
        checkOutput("rst out_ina", out_ina, 32'd0);
        checkOutput("rst out_inb", out_inb, 32'd0);
        checkOutput("rst out_rd", {27'd0, out_rd}, 32'd0);
        checkOutput("rst out_reg_write", {31'd0, out_reg_write}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("post-rst in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("post-rst out_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
